// File: rtl/clk_period_meas.sv
// Measures period and high time of a slow asynchronous input in system-clock cycles,
// with lock detection (repeated equal periods) and loss-of-signal timeout.
module clk_period_meas #(
   parameter int W       = 16,
   parameter int SYNC    = 2,
   parameter int TIMEOUT = 1000,
   parameter int LOCK_N  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clkin,
   output logic [W-1:0] period,
   output logic [W-1:0] high,
   output logic         valid,
   output logic         locked,
   output logic         timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int MW = $clog2(LOCK_N + 1);
   localparam logic [W-1:0]  CMAX   = {W{1'b1}};
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [MW-1:0] M_SAT  = MW'(LOCK_N);
   localparam logic [MW-1:0] M_LOCK = MW'(LOCK_N - 1);

   typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

   state_t          state;
   state_t          state_nx;
   logic [SYNC-1:0] sync;
   logic            s;
   logic            p;
   logic            rise;
   logic            fall;
   logic [W-1:0]    cnt;
   logic [W-1:0]    hcnt;
   logic [W-1:0]    hlat;
   logic [TW-1:0]   tcnt;
   logic [MW-1:0]   mcnt;
   logic [MW-1:0]   mcnt_nx;
   logic            seen_fall;
   logic            ld;
   logic            tmo_hit;
   logic [W-1:0]    new_per;
   logic [W-1:0]    new_high;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == CMAX) ? CMAX : v + W'(1);
   endfunction

   assign s    = sync[SYNC-1];
   assign rise = s & ~p;
   assign fall = ~s & p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         p    <= 1'b0;
      end else begin
         sync <= {sync[SYNC-2:0], clkin};
         p    <= s;
      end
   end

   // Free-running counters: period, high time, idle time, and the high-time latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         hcnt      <= '0;
         hlat      <= '0;
         tcnt      <= '0;
         seen_fall <= 1'b0;
      end else begin
         if (rise) begin
            cnt       <= '0;
            hcnt      <= '0;
            tcnt      <= '0;
            seen_fall <= 1'b0;
         end else begin
            cnt  <= sat_inc(cnt);
            hcnt <= s ? sat_inc(hcnt) : hcnt;
            tcnt <= (tcnt == T_MAX) ? T_MAX : tcnt + TW'(1);
            if (fall) begin
               hlat      <= sat_inc(hcnt);
               seen_fall <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A rise in the threshold cycle wins over the timeout.
   always_comb begin
      state_nx = state;
      ld       = 1'b0;
      tmo_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) state_nx = MEAS;
            else      state_nx = IDLE;
         end
         MEAS: begin
            if (rise) begin
               ld = 1'b1;
            end else if (tcnt == T_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = MEAS;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A rise with no fall since the previous one means the input never went low.
   always_comb begin
      new_per  = sat_inc(cnt);
      new_high = seen_fall ? hlat : new_per;
      if (new_per == period) begin
         if (mcnt == M_SAT) mcnt_nx = M_SAT;
         else               mcnt_nx = mcnt + MW'(1);
      end else begin
         mcnt_nx = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period  <= '0;
         high    <= '0;
         valid   <= 1'b0;
         locked  <= 1'b0;
         timeout <= 1'b0;
         mcnt    <= '0;
      end else begin
         valid   <= ld;
         timeout <= tmo_hit;
         if (ld) begin
            period <= new_per;
            high   <= new_high;
            mcnt   <= mcnt_nx;
            locked <= (mcnt_nx >= M_LOCK);
         end else if (tmo_hit) begin
            period <= '0;
            high   <= '0;
            mcnt   <= '0;
            locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_period_meas.sv
// Randomised bench for clk_period_meas: an edge-timing reference model feeds a
// queue of expected output events, drained and compared by a monitor each cycle.
module tb_clk_period_meas;

   localparam int W       = 6;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 100;
   localparam int LOCK_N  = 4;
   localparam int MAXV    = (1 << W) - 1;

   typedef struct {
      bit tmo;
      int per;
      int hi;
      bit lk;
      int when;
   } ev_t;

   logic         clk;
   logic         rst_n;
   logic         clkin;
   logic [W-1:0] period;
   logic [W-1:0] high;
   logic         valid;
   logic         locked;
   logic         timeout;

   int  errors = 0;
   int  checks = 0;
   int  cyc    = 0;
   ev_t q[$];

   clk_period_meas #(.W(W), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clkin   (clkin),
      .period  (period),
      .high    (high),
      .valid   (valid),
      .locked  (locked),
      .timeout (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
      end
   endtask

   // Reference model: works on edge times of the synchronised input, not on RTL state.
   initial begin : model
      bit m_s, m_ps, m_rise, m_fall, m_armed, m_seen_fall, m_lk;
      int m_last_rise, m_last_fall, m_per, m_hi;
      bit smp[$];
      int plist[$];
      m_ps = 1'b0; m_armed = 1'b0; m_seen_fall = 1'b0;
      m_last_rise = 0; m_last_fall = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cyc = 0;
            smp.delete();
            plist.delete();
            q.delete();
            m_ps = 1'b0; m_armed = 1'b0; m_seen_fall = 1'b0;
         end else begin
            cyc++;
            smp.push_back(clkin);
            m_s    = (smp.size() >= SYNC) ? smp[smp.size() - SYNC] : 1'b0;
            m_rise = m_s & ~m_ps;
            m_fall = ~m_s & m_ps;
            if (m_rise) begin
               if (m_armed) begin
                  m_per = cyc - m_last_rise;
                  if (m_per > MAXV) m_per = MAXV;
                  if (m_seen_fall) begin
                     m_hi = m_last_fall - m_last_rise;
                     if (m_hi > MAXV) m_hi = MAXV;
                  end else begin
                     m_hi = m_per;
                  end
                  plist.push_back(m_per);
                  m_lk = (plist.size() >= LOCK_N);
                  for (int i = 1; i < LOCK_N; i++)
                     if (m_lk && plist[plist.size() - 1 - i] != m_per) m_lk = 1'b0;
                  q.push_back('{tmo: 1'b0, per: m_per, hi: m_hi, lk: m_lk, when: cyc + 1});
               end
               m_armed     = 1'b1;
               m_last_rise = cyc;
               m_seen_fall = 1'b0;
            end else if (m_armed && (cyc - m_last_rise == TIMEOUT)) begin
               q.push_back('{tmo: 1'b1, per: 0, hi: 0, lk: 1'b0, when: cyc + 1});
               m_armed = 1'b0;
               plist.delete();
            end
            if (m_fall) begin
               m_last_fall = cyc;
               m_seen_fall = 1'b1;
            end
            m_ps = m_s;
         end
      end
   end

   // Monitor: every cycle, compare all outputs against the last expected event.
   initial begin : monitor
      ev_t ev;
      bit  exp_v, exp_t, cur_l;
      int  cur_p, cur_h;
      cur_p = 0; cur_h = 0; cur_l = 1'b0;
      forever begin
         @(negedge clk);
         exp_v = 1'b0;
         exp_t = 1'b0;
         if (!rst_n) begin
            cur_p = 0; cur_h = 0; cur_l = 1'b0;
         end else if (q.size() > 0 && q[0].when == cyc) begin
            ev = q.pop_front();
            if (ev.tmo) exp_t = 1'b1;
            else        exp_v = 1'b1;
            cur_p = ev.per; cur_h = ev.hi; cur_l = ev.lk;
         end
         chk("valid",   valid,   exp_v);
         chk("timeout", timeout, exp_t);
         chk("period",  period,  cur_p);
         chk("high",    high,    cur_h);
         chk("locked",  locked,  cur_l);
      end
   end

   task automatic wave(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         clkin = 1'b1;
         repeat (hi) @(negedge clk);
         clkin = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   initial begin : stim
      int hi, lo;
      rst_n = 1'b0;
      clkin = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);

      wave(3, 3, 8);
      wave(2, 5, 6);
      wave(4, 4, 6);
      repeat (120) @(negedge clk);
      wave(3, 3, 3);

      wave(1, 62, 2);
      wave(1, 63, 3);
      wave(3, 97, 3);
      wave(3, 98, 2);
      wave(70, 10, 2);

      wave(3, 3, 5);
      #3 rst_n = 1'b0;
      #1;
      chk("async_period", period,  0);
      chk("async_high",   high,    0);
      chk("async_locked", locked,  0);
      chk("async_valid",  valid,   0);
      clkin = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      wave(2, 2, 6);
      wave(3, 3, 6);

      for (int r = 0; r < 12; r++) begin
         hi = $urandom_range(1, 8);
         lo = ($urandom_range(0, 4) == 0) ? $urandom_range(95, 105) : $urandom_range(1, 8);
         wave(hi, lo, $urandom_range(2, 6));
      end

      clkin = 1'b0;
      repeat (TIMEOUT + 10) @(negedge clk);
      chk("pending_events", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_period_meas.md
Name: clk_period_meas

Overview:
Measures a slow, asynchronous clock or strobe (for example a divided clock from the clock divider) against the system clock. Reports period and high time in system-clock cycles, and flags lock and loss-of-signal. It is the receiving end of the divider: it recovers the divide ratio P from the divided output. It is used in self-checking benches and in on-chip clock monitors.

Parameters:
W, 16, width of period/high counters and outputs
SYNC, 2, synchronizer depth on clkin (>=2)
TIMEOUT, 1000, clk cycles without a clkin rising edge before loss-of-signal (1 < TIMEOUT < 2^W+1 not required; independent of W)
LOCK_N, 4, consecutive equal period measurements required to assert locked (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clkin  in  1  measured signal, asynchronous to clk
period  out  W  clk cycles between last two clkin rising edges
high  out  W  clk cycles clkin was high within that period
valid  out  1  one-cycle pulse: period/high updated this cycle
locked  out  1  LOCK_N consecutive identical periods seen
timeout  out  1  one-cycle pulse: loss-of-signal detected

Behaviour:
- Reset values: period=0, high=0, valid=0, locked=0, timeout=0. Sync chain and edge-history flop are 0; state=IDLE; counters=0.
- clkin passes through a SYNC-flop chain, giving s. Edge detect uses one more flop p: rise = s & ~p, fall = ~s & p.
- Cycle counter cnt, W bits, saturating at 2^W-1:
  - cnt=0 in the rise cycle.
  - Otherwise it increments each cycle.
- High counter hcnt:
  - Captured into an internal hlat at fall as hcnt+1, saturating.
  - hcnt=0 at rise and counts while s=1.
- Idle-time counter tcnt (separate, ceil(log2(TIMEOUT+1)) bits): cleared on rise, increments otherwise.
- States:
  - IDLE: waiting for the first edge. On rise, go to MEAS. No valid is issued, so the first edge only arms the block. This makes a clkin held high at reset release harmless.
  - MEAS: on each rise:
    - period <= sat(cnt+1), high <= hlat, valid=1 in the same cycle the registers update.
    - If s rose without a fall since the previous rise (impossible for a clean clock), high <= period value.
- Latency: the valid cycle is the SYNC+1th clk rising edge after the first one that samples clkin=1.
- Lock:
  - A match counter increments when the new period equals the previous period, saturating at LOCK_N.
  - locked=1 once the match counter reaches LOCK_N-1 (LOCK_N=1: locked on the first valid).
  - A mismatch clears the match counter and locked in the same cycle that valid reports the new period.
- Timeout:
  - In MEAS, if tcnt reaches TIMEOUT with no rise: timeout=1 for one cycle, state goes to IDLE.
  - locked=0, match counter=0, period=0, high=0.
  - No timeout is generated from IDLE.
- Saturation: edges farther apart than 2^W-1 cycles report period=2^W-1. Comparisons for lock use the saturated value.
- Simultaneous rise and timeout threshold in the same cycle: rise wins, no timeout.
- rst_n asserted mid-measurement: all outputs return to reset values immediately (async). Measurement restarts from IDLE after release.

Test Plan:
- clkin = clk/6 (3 high, 3 low, period 60 ns at 100 MHz clk), LOCK_N=4 -> first valid at second rise; period=6, high=3 every valid; locked=1 coincident with the 4th valid.
- clkin 2 cycles high, 5 low -> period=7, high=2. Then switch to 4 high / 4 low -> the first new valid shows period=8, high=4, with locked=0 in that cycle; relocks after 3 further equal periods.
- TIMEOUT=64, clkin stopped (held low) while locked -> exactly one timeout pulse 64 cycles after the last rise; period=0, locked=0. The next two clkin rises give one valid with the correct period.
- W=4, clkin period 20 clk cycles, TIMEOUT=100 -> period=15 (saturated), no timeout, locked after LOCK_N valids.
- clkin high at rst_n release, then clk/4 -> the first sync rise only arms; the first valid reports period=4, high=2.
- rst_n pulsed low mid-run with clkin=clk/6 -> outputs 0 asynchronously; after release, the first valid occurs at the second clkin rise with period=6.
